// File: rtl/mem_bus_pkg.sv
// Shared encodings and helpers for the main-memory bus master.
// Access sizes, master FSM states and the alignment check.
package mem_bus_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RMW_CAP,
        RMW_WR
    } state_t;

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] lsb
    );
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return lsb[0];
            SIZE_W:  return (lsb != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane extraction for loads and lane merge for sub-word stores.
// Little-endian: lane 0 is bits 7:0.
module mem_lane_align
    import mem_bus_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [31:0] st_word,
    input  logic [31:0] st_data,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] ld_data,
    output logic [31:0] st_merged
);

    logic [15:0] sh;
    logic [31:0] mask;
    logic [31:0] rep;

    always_comb begin
        sh      = 16'(ld_word >> {lane, 3'b000});
        ld_data = ld_word;
        mask    = '1;
        rep     = st_data;
        case (size)
            SIZE_B: begin
                ld_data = {{24{sgn & sh[7]}}, sh[7:0]};
                mask    = 32'h0000_00FF << {lane, 3'b000};
                rep     = {4{st_data[7:0]}};
            end
            SIZE_H: begin
                ld_data = {{16{sgn & sh[15]}}, sh[15:0]};
                mask    = 32'h0000_FFFF << {lane[1], 4'b0000};
                rep     = {2{st_data[15:0]}};
            end
            default: ;
        endcase
        st_merged = (st_word & ~mask) | (rep & mask);
    end

endmodule

// File: rtl/mem_bus_master.sv
// CPU-side initiator for the phase-alternating single-port memory.
// Fetch on execute phases, byte/half/word data access with RMW stores.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] core_pc_next,
    input  logic              core_adv,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_out,
    output logic              stall,
    input  logic              mem_E,
    input  logic [DATA_W-1:0] mem_Mout,
    output logic [ADDR_W-1:0] mem_Next_PC,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_S
);

    state_t state_q, state_d;

    logic [ADDR_W-1:0] pc_q;
    logic              first_q;
    logic              ld_q;
    logic              ack_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] buf_q;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] st_merged;

    logic accept;
    logic mis;
    logic is_word;

    assign req_ready   = (state_q == IDLE) & mem_E & ~Reset;
    assign accept      = req_valid & req_ready;
    assign mis         = misaligned(req_size, req_addr[1:0]);
    assign is_word     = (req_size == SIZE_W);
    assign stall       = (state_q != IDLE);
    assign mem_Next_PC = pc_q;

    mem_lane_align u_align (
        .ld_word   (mem_Mout),
        .st_word   (buf_q),
        .st_data   (wdata_q),
        .lane      (addr_q[1:0]),
        .size      (size_q),
        .sgn       (sgn_q),
        .ld_data   (ld_data),
        .st_merged (st_merged)
    );

    always_ff @(posedge clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mem_S     = 1'b0;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        unique case (state_q)
            IDLE: begin
                if (accept & ~mis & req_we) begin
                    if (is_word) mem_S   = 1'b1;
                    else         state_d = RMW_CAP;
                end
            end
            RMW_CAP: state_d = RMW_WR;
            RMW_WR: begin
                mem_addr  = addr_q;
                mem_wdata = st_merged;
                mem_S     = mem_E;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (Reset) mem_S = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            pc_q        <= '0;
            first_q     <= 1'b1;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            ld_q        <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            first_q <= 1'b0;
            if (core_adv & mem_E & ~stall)
                pc_q <= core_pc_next;
            instr_valid <= mem_E & ~first_q;
            if (mem_E & ~first_q)
                instr_out <= mem_Mout;
            ld_q  <= accept & ~mis & ~req_we;
            err_q <= accept & mis;
            ack_q <= (accept & ~mis & req_we & is_word)
                   | (state_q == RMW_WR);
        end
    end

    // Request fields only matter while a request is in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            wdata_q <= req_wdata;
        end
        if (state_q == RMW_CAP)
            buf_q <= mem_Mout;
    end

    // Load data comes straight off the memory in the cycle after accept.
    assign rsp_valid = ld_q | ack_q | err_q;
    assign rsp_err   = err_q;
    assign rsp_rdata = ld_q ? ld_data : '0;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a phase-alternating memory model.
// Each task drives one scenario and checks against hand-computed values.
module tb_mem_bus_master;

    logic        clk = 1'b0;
    logic        Reset;
    logic [31:0] core_pc_next;
    logic        core_adv;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic        stall;
    logic        mem_E;
    logic [31:0] mem_Mout;
    logic [31:0] mem_Next_PC;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_S;

    int checks = 0;
    int errors = 0;
    int s_cnt  = 0;
    int s_bad  = 0;
    int rsp_cnt = 0;
    logic win = 1'b0;

    always #5 clk = ~clk;

    mem_bus_master dut (
        .clk          (clk),
        .Reset        (Reset),
        .core_pc_next (core_pc_next),
        .core_adv     (core_adv),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .instr_valid  (instr_valid),
        .instr_out    (instr_out),
        .stall        (stall),
        .mem_E        (mem_E),
        .mem_Mout     (mem_Mout),
        .mem_Next_PC  (mem_Next_PC),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_S        (mem_S)
    );

    // Memory model: fetch address latched on E=0 edges, data access on E=1 edges.
    logic [31:0] mem [0:15];
    logic        E;
    logic [31:0] rd;
    logic        inited = 1'b0;

    always @(posedge clk) begin
        if (!inited) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + i;
            mem[4] <= 32'hDEAD_BEEF;
            mem[5] <= 32'h0;
            inited <= 1'b1;
        end else if (E) begin
            if (mem_S) mem[mem_addr[5:2]] <= mem_wdata;
            rd <= mem[mem_addr[5:2]];
        end else begin
            rd <= mem[mem_Next_PC[5:2]];
        end
        if (Reset) E <= 1'b0;
        else       E <= ~E;
    end

    assign mem_E    = E;
    assign mem_Mout = rd;

    always @(posedge clk) begin
        if (mem_S) begin
            s_cnt++;
            if (!mem_E) s_bad++;
        end
        if (win && rsp_valid) rsp_cnt++;
    end

    task automatic sync_e1();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_E && n < 4);
        checks++;
        if (mem_E !== 1'b1) begin
            errors++;
            $display("FAIL sync_e1 mem_E=%b want 1", mem_E);
        end
    endtask

    task automatic drive_req(input logic we, input logic [1:0] sz,
                             input logic sg, input logic [31:0] a,
                             input logic [31:0] d);
        sync_e1();
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = d;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL rst_ready got %b want 0", req_ready);
        end
        checks++;
        if ({rsp_valid, instr_valid, stall, mem_S} !== 4'b0) begin
            errors++;
            $display("FAIL rst_flags got %b want 0000",
                     {rsp_valid, instr_valid, stall, mem_S});
        end
        checks++;
        if (mem_Next_PC !== 32'h0) begin
            errors++; $display("FAIL rst_pc got %h want 0", mem_Next_PC);
        end
        Reset = 1'b0;
    endtask

    task automatic test_fetch();
        logic [31:0] exp_i [3];
        exp_i = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002};
        for (int k = 0; k < 3; k++) begin
            sync_e1();
            #1;
            checks++;
            if (instr_valid !== 1'b0) begin
                errors++; $display("FAIL fetch_gap%0d got %b want 0", k, instr_valid);
            end
            core_adv     = 1'b1;
            core_pc_next = 32'(4 * (k + 1));
            @(negedge clk);
            core_adv = 1'b0;
            #1;
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== exp_i[k]) begin
                errors++;
                $display("FAIL fetch%0d got v=%b %h want v=1 %h",
                         k, instr_valid, instr_out, exp_i[k]);
            end
        end
        checks++;
        if (mem_Next_PC !== 32'hC) begin
            errors++; $display("FAIL fetch_pc got %h want c", mem_Next_PC);
        end
    endtask

    task automatic test_loads();
        logic [31:0] a_t [4];
        logic [1:0]  z_t [4];
        logic        s_t [4];
        logic [31:0] e_t [4];
        a_t = '{32'h10, 32'h13, 32'h12, 32'h10};
        z_t = '{2'b10, 2'b00, 2'b01, 2'b00};
        s_t = '{1'b0, 1'b1, 1'b0, 1'b0};
        e_t = '{32'hDEAD_BEEF, 32'hFFFF_FFDE, 32'h0000_DEAD, 32'h0000_00EF};
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b0, z_t[i], s_t[i], a_t[i], 32'h0);
            #1;
            checks++;
            if (req_ready !== 1'b1 || mem_S !== 1'b0) begin
                errors++;
                $display("FAIL ld%0d_acc got rdy=%b S=%b want 1 0", i, req_ready, mem_S);
            end
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== e_t[i]) begin
                errors++;
                $display("FAIL ld%0d got v=%b e=%b %h want v=1 e=0 %h",
                         i, rsp_valid, rsp_err, rsp_rdata, e_t[i]);
            end
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++; $display("FAIL ld%0d_pulse got %b want 0", i, rsp_valid);
            end
        end
    endtask

    task automatic test_subword_store();
        drive_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h55);
        #1;
        checks++;
        if (mem_S !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL sb_acc got S=%b stall=%b want 0 0", mem_S, stall);
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1 || mem_S !== 1'b0) begin
            errors++; $display("FAIL sb_cap got stall=%b S=%b want 1 0", stall, mem_S);
        end
        @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b1 || mem_S !== 1'b1 || mem_wdata !== 32'hDEAD_55EF
            || mem_addr !== 32'h11 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL sb_wr got stall=%b S=%b wd=%h a=%h rdy=%b want 1 1 dead55ef 11 0",
                     stall, mem_S, mem_wdata, mem_addr, req_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || stall !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL sb_rsp got v=%b stall=%b %h want 1 0 0", rsp_valid, stall, rsp_rdata);
        end
        checks++;
        if (mem[4] !== 32'hDEAD_55EF) begin
            errors++; $display("FAIL sb_mem got %h want dead55ef", mem[4]);
        end
    endtask

    task automatic test_word_store();
        drive_req(1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFE_F00D);
        #1;
        checks++;
        if (mem_S !== 1'b1 || mem_wdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL sw_acc got S=%b %h want 1 cafef00d", mem_S, mem_wdata);
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || mem[5] !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL sw_rsp got v=%b mem=%h want 1 cafef00d", rsp_valid, mem[5]);
        end
    endtask

    task automatic test_after_store();
        logic [31:0] a_t [3];
        logic [1:0]  z_t [3];
        logic [31:0] e_t [3];
        a_t = '{32'h12, 32'h10, 32'h10};
        z_t = '{2'b01, 2'b01, 2'b10};
        e_t = '{32'hFFFF_DEAD, 32'h0000_55EF, 32'hDEAD_55EF};
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b0, z_t[i], 1'b1, a_t[i], 32'h0);
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e_t[i]) begin
                errors++;
                $display("FAIL lds%0d got v=%b %h want 1 %h", i, rsp_valid, rsp_rdata, e_t[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        logic        w_t [3];
        logic [1:0]  z_t [3];
        logic [31:0] a_t [3];
        int s0;
        w_t = '{1'b0, 1'b1, 1'b0};
        z_t = '{2'b10, 2'b01, 2'b11};
        a_t = '{32'h12, 32'h13, 32'h10};
        s0 = s_cnt;
        for (int i = 0; i < 3; i++) begin
            drive_req(w_t[i], z_t[i], 1'b0, a_t[i], 32'hFFFF);
            #1;
            checks++;
            if (mem_S !== 1'b0) begin
                errors++; $display("FAIL mis%0d_S got %b want 0", i, mem_S);
            end
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0
                || stall !== 1'b0) begin
                errors++;
                $display("FAIL mis%0d got v=%b e=%b %h st=%b want 1 1 0 0",
                         i, rsp_valid, rsp_err, rsp_rdata, stall);
            end
        end
        checks++;
        if (mem[4] !== 32'hDEAD_55EF || s_cnt !== s0) begin
            errors++;
            $display("FAIL mis_mem got %h strobes=%0d want dead55ef 0", mem[4], s_cnt - s0);
        end
    endtask

    task automatic test_reset_rmw();
        drive_req(1'b1, 2'b00, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL rr_cap got stall=%b want 1", stall);
        end
        rsp_cnt = 0;
        win   = 1'b1;
        Reset = 1'b1;
        repeat (2) @(negedge clk);
        Reset = 1'b0;
        repeat (4) @(negedge clk);
        win = 1'b0;
        checks++;
        if (mem[4] !== 32'hDEAD_55EF || rsp_cnt !== 0) begin
            errors++;
            $display("FAIL rr_abandon got mem=%h rsp=%0d want dead55ef 0", mem[4], rsp_cnt);
        end
        sync_e1();
        #1;
        checks++;
        if (req_ready !== 1'b1 || stall !== 1'b0) begin
            errors++; $display("FAIL rr_ready got rdy=%b st=%b want 1 0", req_ready, stall);
        end
    endtask

    initial begin
        Reset        = 1'b1;
        core_adv     = 1'b0;
        core_pc_next = '0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_signed   = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_fetch();
        test_loads();
        test_subword_store();
        test_word_store();
        test_after_store();
        test_misaligned();
        test_reset_rmw();
        checks++;
        if (s_bad !== 0) begin
            errors++; $display("FAIL strobe_phase got %0d want 0", s_bad);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
